// File: rtl/conv_serial_engine_if.sv
// Bus bundle for the serial convolution engine: start/status handshake,
// the three-port input-matrix and filter RAM read buses, and the S_OUT write bus.
interface conv_serial_engine_if #(
    parameter int DW = 8
);
    logic          start;
    logic          busy;
    logic          done;
    logic          ovf;
    logic [3:0]    addr_A0;
    logic [3:0]    addr_A1;
    logic [3:0]    addr_A2;
    logic [3:0]    addr_F0;
    logic [3:0]    addr_F1;
    logic [3:0]    addr_F2;
    logic [DW-1:0] in_A0;
    logic [DW-1:0] in_A1;
    logic [DW-1:0] in_A2;
    logic [DW-1:0] in_F0;
    logic [DW-1:0] in_F1;
    logic [DW-1:0] in_F2;
    logic [1:0]    en_INP;
    logic [1:0]    en_FIL;
    logic [DW-1:0] wr_data;
    logic [1:0]    addr_S;
    logic [1:0]    en_S;

    // Engine side: drives RAM addresses/enables and status, consumes read data.
    modport master (
        input  start,
        output busy, done, ovf,
        output addr_A0, addr_A1, addr_A2,
        output addr_F0, addr_F1, addr_F2,
        input  in_A0, in_A1, in_A2,
        input  in_F0, in_F1, in_F2,
        output en_INP, en_FIL,
        output wr_data, addr_S, en_S
    );

    // Host/RAM side: issues start, returns read data, observes writes.
    modport slave (
        output start,
        input  busy, done, ovf,
        input  addr_A0, addr_A1, addr_A2,
        input  addr_F0, addr_F1, addr_F2,
        output in_A0, in_A1, in_A2,
        output in_F0, in_F1, in_F2,
        input  en_INP, en_FIL,
        input  wr_data, addr_S, en_S
    );
endinterface

// File: rtl/conv_serial_engine.sv
// Serial 2D convolution engine: 4x4 input, 3x3 filter, 2x2 output (stride 1,
// no padding). One filter row is multiply-accumulated per step through the three
// read ports of each input RAM; each finished pixel is shifted, saturated and
// written to the S_OUT RAM.
module conv_serial_engine #(
    parameter int DW     = 8,
    parameter int RD_LAT = 1,
    parameter int SHIFT  = 0
) (
    input logic                clk,
    input logic                rst,
    conv_serial_engine_if.master bus
);
    localparam int  PW   = 2 * DW;       // one product
    localparam int  RW   = PW + 2;       // sum of three products
    localparam int  AW   = PW + 4;       // sum of three row sums
    localparam bit  LAT1 = (RD_LAT != 0);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_ACC, S_WR, S_DONE} state_t;

    state_t          state;
    logic            r;
    logic            c;
    logic [1:0]      k;
    logic [AW-1:0]   acc;

    logic [PW-1:0]   prod0, prod1, prod2;
    logic [RW-1:0]   rowsum;
    logic [AW-1:0]   acc_next;
    logic            ld_r, ld_c;
    logic [1:0]      ld_k;
    logic [1:0]      row;
    logic [3:0]      nxt_a0;
    logic [3:0]      nxt_f0;

    // Shift the accumulator and clamp it to the largest DW-bit value.
    function automatic logic [DW-1:0] sat_val(input logic [AW-1:0] v);
        logic [AW-1:0] q;
        q = v >> SHIFT;
        return (|q[AW-1:DW]) ? {DW{1'b1}} : q[DW-1:0];
    endfunction

    // True when the shifted accumulator does not fit in DW bits.
    function automatic logic sat_hit(input logic [AW-1:0] v);
        logic [AW-1:0] q;
        q = v >> SHIFT;
        return |q[AW-1:DW];
    endfunction

    // Row multiply-accumulate; products are unsigned and the sums never wrap.
    always_comb begin
        prod0    = {{DW{1'b0}}, bus.in_A0} * {{DW{1'b0}}, bus.in_F0};
        prod1    = {{DW{1'b0}}, bus.in_A1} * {{DW{1'b0}}, bus.in_F1};
        prod2    = {{DW{1'b0}}, bus.in_A2} * {{DW{1'b0}}, bus.in_F2};
        rowsum   = {2'b00, prod0} + {2'b00, prod1} + {2'b00, prod2};
        acc_next = (k == 2'd0) ? {2'b00, rowsum} : acc + {2'b00, rowsum};
    end

    // Coordinates and base addresses of the next RD step, so the registered
    // addresses are already valid in the first RD cycle.
    always_comb begin
        ld_r = 1'b0;
        ld_c = 1'b0;
        ld_k = 2'd0;
        if (state == S_WR) begin
            {ld_r, ld_c} = {r, c} + 2'd1;
        end else if (state == S_RD || state == S_ACC) begin
            ld_r = r;
            ld_c = c;
            ld_k = k + 2'd1;
        end
        row    = ld_k + {1'b0, ld_r};
        nxt_a0 = {row, 2'b00} + {3'b000, ld_c};
        nxt_f0 = {1'b0, ld_k, 1'b0} + {2'b00, ld_k};
    end

    // Control FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            r           <= 1'b0;
            c           <= 1'b0;
            k           <= 2'd0;
            acc         <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.ovf     <= 1'b0;
            bus.addr_A0 <= 4'd0;
            bus.addr_A1 <= 4'd0;
            bus.addr_A2 <= 4'd0;
            bus.addr_F0 <= 4'd0;
            bus.addr_F1 <= 4'd0;
            bus.addr_F2 <= 4'd0;
            bus.en_INP  <= 2'b00;
            bus.en_FIL  <= 2'b00;
            bus.wr_data <= '0;
            bus.addr_S  <= 2'd0;
            bus.en_S    <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state       <= S_RD;
                        r           <= 1'b0;
                        c           <= 1'b0;
                        k           <= 2'd0;
                        bus.busy    <= 1'b1;
                        bus.ovf     <= 1'b0;
                        bus.en_INP  <= 2'b10;
                        bus.en_FIL  <= 2'b10;
                        bus.addr_A0 <= nxt_a0;
                        bus.addr_A1 <= nxt_a0 + 4'd1;
                        bus.addr_A2 <= nxt_a0 + 4'd2;
                        bus.addr_F0 <= nxt_f0;
                        bus.addr_F1 <= nxt_f0 + 4'd1;
                        bus.addr_F2 <= nxt_f0 + 4'd2;
                    end
                end
                S_RD, S_ACC: begin
                    if (state == S_RD && LAT1) begin
                        // Registered RAM: data for these addresses arrives next cycle.
                        state <= S_ACC;
                    end else begin
                        acc <= acc_next;
                        if (k == 2'd2) begin
                            state       <= S_WR;
                            bus.en_INP  <= 2'b00;
                            bus.en_FIL  <= 2'b00;
                            bus.wr_data <= sat_val(acc_next);
                            bus.ovf     <= bus.ovf | sat_hit(acc_next);
                            bus.addr_S  <= {r, c};
                            bus.en_S    <= 2'b11;
                        end else begin
                            state       <= S_RD;
                            k           <= ld_k;
                            bus.addr_A0 <= nxt_a0;
                            bus.addr_A1 <= nxt_a0 + 4'd1;
                            bus.addr_A2 <= nxt_a0 + 4'd2;
                            bus.addr_F0 <= nxt_f0;
                            bus.addr_F1 <= nxt_f0 + 4'd1;
                            bus.addr_F2 <= nxt_f0 + 4'd2;
                        end
                    end
                end
                S_WR: begin
                    bus.en_S <= 2'b00;
                    if ({r, c} == 2'b11) begin
                        state    <= S_DONE;
                        bus.done <= 1'b1;
                    end else begin
                        state       <= S_RD;
                        r           <= ld_r;
                        c           <= ld_c;
                        k           <= 2'd0;
                        bus.en_INP  <= 2'b10;
                        bus.en_FIL  <= 2'b10;
                        bus.addr_A0 <= nxt_a0;
                        bus.addr_A1 <= nxt_a0 + 4'd1;
                        bus.addr_A2 <= nxt_a0 + 4'd2;
                        bus.addr_F0 <= nxt_f0;
                        bus.addr_F1 <= nxt_f0 + 4'd1;
                        bus.addr_F2 <= nxt_f0 + 4'd2;
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_conv_serial_engine.sv
// Bench for conv_serial_engine: three engines (registered RAM, combinational RAM,
// registered RAM with SHIFT=12) share one matrix/filter image. Runs push the
// expected S_OUT writes into a scoreboard; per-engine monitors pop and compare.
module tb_conv_serial_engine;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] mat [16];
    logic [7:0] fil [16];

    typedef struct packed {
        logic [1:0] inst;
        logic [1:0] addr;
        logic [7:0] data;
    } exp_t;
    exp_t sb [$];

    int n_chk  = 0;
    int n_fail = 0;

    logic [2:0] start_v;
    logic [2:0] busy_v;
    logic [2:0] done_v;
    logic [2:0] ovf_v;
    logic [1:0] ens_v  [3];
    logic [1:0] adds_v [3];
    logic [7:0] wd_v   [3];
    logic [1:0] eni_v  [3];
    logic [1:0] enf_v  [3];
    logic [3:0] aa0_v  [3];
    logic [3:0] af2_v  [3];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 1) ? 0 : 1;
        localparam int SH  = (g == 2) ? 12 : 0;

        conv_serial_engine_if #(.DW(8)) ifc ();

        conv_serial_engine #(.DW(8), .RD_LAT(LAT), .SHIFT(SH)) dut (
            .clk(clk),
            .rst(rst),
            .bus(ifc.master)
        );

        assign ifc.start = start_v[g];
        assign busy_v[g] = ifc.busy;
        assign done_v[g] = ifc.done;
        assign ovf_v[g]  = ifc.ovf;
        assign ens_v[g]  = ifc.en_S;
        assign adds_v[g] = ifc.addr_S;
        assign wd_v[g]   = ifc.wr_data;
        assign eni_v[g]  = ifc.en_INP;
        assign enf_v[g]  = ifc.en_FIL;
        assign aa0_v[g]  = ifc.addr_A0;
        assign af2_v[g]  = ifc.addr_F2;

        if (LAT == 1) begin : g_ram
            always @(posedge clk) begin
                ifc.in_A0 <= mat[ifc.addr_A0];
                ifc.in_A1 <= mat[ifc.addr_A1];
                ifc.in_A2 <= mat[ifc.addr_A2];
                ifc.in_F0 <= fil[ifc.addr_F0];
                ifc.in_F1 <= fil[ifc.addr_F1];
                ifc.in_F2 <= fil[ifc.addr_F2];
            end
        end else begin : g_ram
            always_comb begin
                ifc.in_A0 = mat[ifc.addr_A0];
                ifc.in_A1 = mat[ifc.addr_A1];
                ifc.in_A2 = mat[ifc.addr_A2];
                ifc.in_F0 = fil[ifc.addr_F0];
                ifc.in_F1 = fil[ifc.addr_F1];
                ifc.in_F2 = fil[ifc.addr_F2];
            end
        end

        always @(negedge clk) begin : mon
            exp_t e;
            if (ifc.en_S == 2'b11) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write inst %0d: addr %0d data %0d, expected no write",
                             g, ifc.addr_S, ifc.wr_data);
                end else begin
                    e = sb.pop_front();
                    chk("wr_inst", g, e.inst);
                    chk("wr_addr", ifc.addr_S, e.addr);
                    chk("wr_data", ifc.wr_data, e.data);
                end
            end else if (ifc.en_S != 2'b00) begin
                n_chk++;
                n_fail++;
                $display("FAIL en_S_value inst %0d: got %0d, expected 0 or 3", g, ifc.en_S);
            end
            if (ifc.en_INP[0] || ifc.en_FIL[0]) begin
                n_chk++;
                n_fail++;
                $display("FAIL ram_we inst %0d: en_INP %0d en_FIL %0d, expected write bit 0",
                         g, ifc.en_INP, ifc.en_FIL);
            end
        end
    end

    // One convolution on engine inst. abort_at>0 pulls rst low in that cycle.
    task automatic run(input int inst, input int exp_cyc,
                       input int e0, input int e1, input int e2, input int e3,
                       input int exp_ovf, input bit repulse, input int abort_at);
        int n;
        bit seen;
        int ev [4];
        ev = '{e0, e1, e2, e3};
        @(negedge clk);
        for (int p = 0; p < ((abort_at > 0) ? 1 : 4); p++)
            sb.push_back('{inst: 2'(inst), addr: 2'(p), data: 8'(ev[p])});
        start_v[inst] = 1'b1;
        n = 0;
        seen = 1'b0;
        while (n < 60 && !seen) begin
            @(negedge clk);
            n++;
            start_v[inst] = 1'b0;
            if (repulse && (n == 5 || n == 20)) start_v[inst] = 1'b1;
            if (n == 1) chk("busy_after_start", busy_v[inst], 1);
            if (abort_at > 0) begin
                if (n == abort_at) rst = 1'b0;
                if (n == abort_at + 1) begin
                    rst = 1'b1;
                    chk("abort_busy", busy_v[inst], 0);
                    chk("abort_en_S", ens_v[inst], 0);
                    chk("abort_pixel0_written", sb.size(), 0);
                end
                if (n > abort_at) chk("abort_no_done", done_v[inst], 0);
            end else if (done_v[inst]) begin
                seen = 1'b1;
                chk("done_cycle", n, exp_cyc);
                chk("busy_with_done", busy_v[inst], 1);
            end
        end
        if (abort_at == 0) begin
            if (!seen) begin
                n_chk++;
                n_fail++;
                $display("FAIL done_timeout inst %0d: no done in %0d cycles, expected cycle %0d",
                         inst, n, exp_cyc);
            end
            @(negedge clk);
            chk("busy_after_done", busy_v[inst], 0);
            chk("done_one_cycle", done_v[inst], 0);
            chk("ovf", ovf_v[inst], exp_ovf);
            chk("all_writes_seen", sb.size(), 0);
        end
    endtask

    initial begin
        rst = 1'b0;
        start_v = '0;
        foreach (mat[i]) mat[i] = 8'd0;
        foreach (fil[i]) fil[i] = 8'd0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy", busy_v[i], 0);
            chk("rst_done", done_v[i], 0);
            chk("rst_ovf", ovf_v[i], 0);
            chk("rst_en_S", ens_v[i], 0);
            chk("rst_en_INP", eni_v[i], 0);
            chk("rst_en_FIL", enf_v[i], 0);
            chk("rst_addr_A0", aa0_v[i], 0);
            chk("rst_addr_F2", af2_v[i], 0);
            chk("rst_addr_S", adds_v[i], 0);
            chk("rst_wr_data", wd_v[i], 0);
        end
        rst = 1'b1;

        // T1: all ones -> 9 everywhere, done at cycle 29
        foreach (mat[i]) mat[i] = 8'd1;
        foreach (fil[i]) fil[i] = (i < 9) ? 8'd1 : 8'd0;
        run(0, 29, 9, 9, 9, 9, 0, 1'b0, 0);

        // T2: ramp input, centre-tap filter -> {5,6,9,10}
        foreach (mat[i]) mat[i] = 8'(i);
        foreach (fil[i]) fil[i] = 8'd0;
        fil[4] = 8'd1;
        run(0, 29, 5, 6, 9, 10, 0, 1'b0, 0);

        // T3: full-scale data saturates; SHIFT=12 gives 585225>>12 = 142
        foreach (mat[i]) mat[i] = 8'd255;
        foreach (fil[i]) fil[i] = (i < 9) ? 8'd255 : 8'd0;
        run(0, 29, 255, 255, 255, 255, 1, 1'b0, 0);
        run(2, 29, 142, 142, 142, 142, 0, 1'b0, 0);

        // T4: extra start pulses mid-run are ignored; ovf cleared by new start
        foreach (mat[i]) mat[i] = 8'd1;
        foreach (fil[i]) fil[i] = (i < 9) ? 8'd1 : 8'd0;
        run(0, 29, 9, 9, 9, 9, 0, 1'b1, 0);

        // T5: reset in cycle 10 aborts after pixel 0, then a clean rerun
        run(0, 0, 9, 0, 0, 0, 0, 1'b0, 10);
        foreach (mat[i]) mat[i] = 8'(i);
        foreach (fil[i]) fil[i] = 8'd0;
        fil[4] = 8'd1;
        run(0, 29, 5, 6, 9, 10, 0, 1'b0, 0);

        // T6: combinational-read engine, T2 data, done at cycle 17
        run(1, 17, 5, 6, 9, 10, 0, 1'b0, 0);

        // T7: off-centre taps: A[r*4+c+2] + 2*A[(r+2)*4+c] -> {18,21,30,33}
        foreach (fil[i]) fil[i] = 8'd0;
        fil[2] = 8'd1;
        fil[6] = 8'd2;
        run(0, 29, 18, 21, 30, 33, 0, 1'b0, 0);
        run(1, 17, 18, 21, 30, 33, 0, 1'b0, 0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
